// File: rtl/hist_equalizer_stream.sv
// rtl/hist_equalizer_stream.sv - frame histogram equaliser: remaps frame N through the LUT built from frame N-1
// Histogram is collected while streaming; the LUT is rebuilt between frames via divide + CDF sweep.
module hist_equalizer_stream #(
  parameter int PIX_W  = 8,
  parameter int CNT_W  = 22,
  parameter int FRAC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             busy,
  output logic             lut_valid
);

  localparam int NBINS = 1 << PIX_W;
  localparam int DW    = CNT_W + FRAC_W;
  localparam int SC_W  = PIX_W + FRAC_W;
  localparam int PW    = CNT_W + SC_W;
  localparam int DCW   = $clog2(DW) + 1;
  localparam logic [PIX_W-1:0] PMAX    = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0] DIVIDEND = {{(DW-SC_W){1'b0}}, PMAX, {FRAC_W{1'b0}}};

  typedef enum logic [2:0] {S_STREAM, S_INIT, S_DRAIN, S_CMIN, S_DIV, S_MAP, S_FIN} state_t;

  logic [CNT_W-1:0] hist_mem [NBINS];
  logic [PIX_W-1:0] lut_mem  [NBINS];

  state_t           state_q, state_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic             lut_valid_q, lut_valid_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [PIX_W-1:0] min_pix_q, min_pix_d;
  logic             s1_valid_q, s1_valid_d;
  logic [PIX_W-1:0] s1_pix_q, s1_pix_d;
  logic             s1_last_q, s1_last_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic             out_last_q, out_last_d;
  logic             v1_q, v1_d;
  logic [PIX_W-1:0] a1_q, a1_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cdf_min_q, cdf_min_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic             ident_q, ident_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DW-1:0]    dq_q, dq_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic [PIX_W:0]   idx_q, idx_d;
  logic [CNT_W-1:0] cdf_q, cdf_d;
  logic             m_valid_q, m_valid_d;
  logic [PIX_W-1:0] m_idx_q, m_idx_d;
  logic [CNT_W-1:0] m_cdf_q, m_cdf_d;

  logic             advance, accept;
  logic             hw_en, lw_en;
  logic [PIX_W-1:0] hw_addr, lw_addr, lw_data, map_val;
  logic [CNT_W-1:0] hw_data, diff;
  logic [CNT_W:0]   r_sh, hsum;
  logic             ge;
  logic [PW-1:0]    prod, shifted;

  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    lut_valid_d = lut_valid_q;
    n_d         = n_q;
    min_pix_d   = min_pix_q;
    s1_valid_d  = s1_valid_q;
    s1_pix_d    = s1_pix_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_last_d  = out_last_q;
    cdf_min_d   = cdf_min_q;
    d_d         = d_q;
    ident_d     = ident_q;
    rem_d       = rem_q;
    dq_d        = dq_q;
    div_cnt_d   = div_cnt_q;
    idx_d       = idx_q;
    cdf_d       = cdf_q;
    m_valid_d   = 1'b0;
    m_idx_d     = m_idx_q;
    m_cdf_d     = m_cdf_q;
    r_sh        = '0;
    ge          = 1'b0;
    hsum        = '0;
    lw_en       = 1'b0;
    lw_addr     = m_idx_q;
    lw_data     = '0;

    advance  = !out_valid_q || out_ready;
    in_ready = (state_q == S_STREAM) && init_done_q && advance;
    accept   = in_valid && in_ready;

    // Second half of the histogram read-modify-write, saturating
    hw_en   = v1_q;
    hw_addr = a1_q;
    hw_data = (rd_q == CNT_MAX) ? rd_q : rd_q + 1'b1;

    if (advance) begin
      out_valid_d = s1_valid_q;
      out_pix_d   = s1_pix_q;
      out_last_d  = s1_last_q;
      s1_valid_d  = accept;
      if (accept) begin
        s1_pix_d  = (enable && lut_valid_q) ? lut_mem[in_pixel] : in_pixel;
        s1_last_d = in_last;
      end
    end

    if (accept) begin
      n_d       = (n_q == CNT_MAX) ? n_q : n_q + 1'b1;
      min_pix_d = (in_pixel < min_pix_q) ? in_pixel : min_pix_q;
    end

    case (state_q)
      S_STREAM: begin
        if (!init_done_q) begin
          state_d = S_INIT;
          idx_d   = '0;
        end else if (accept && in_last) begin
          state_d = S_DRAIN;
        end
      end
      S_INIT: begin
        hw_en   = 1'b1;
        hw_addr = idx_q[PIX_W-1:0];
        hw_data = '0;
        idx_d   = idx_q + 1'b1;
        if (idx_q[PIX_W-1:0] == PMAX) begin
          state_d     = S_STREAM;
          init_done_d = 1'b1;
        end
      end
      S_DRAIN: state_d = S_CMIN;
      S_CMIN: begin
        cdf_min_d = hist_mem[min_pix_q];
        d_d       = n_q - hist_mem[min_pix_q];
        ident_d   = (n_q == hist_mem[min_pix_q]);
        rem_d     = '0;
        dq_d      = DIVIDEND;
        div_cnt_d = '0;
        idx_d     = '0;
        cdf_d     = '0;
        state_d   = (n_q == hist_mem[min_pix_q]) ? S_MAP : S_DIV;
      end
      S_DIV: begin
        // Restoring division: dq shifts the dividend out and the quotient in
        r_sh      = {rem_q, dq_q[DW-1]};
        ge        = (r_sh >= {1'b0, d_q});
        rem_d     = ge ? CNT_W'(r_sh - {1'b0, d_q}) : r_sh[CNT_W-1:0];
        dq_d      = {dq_q[DW-2:0], ge};
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DCW'(DW - 1)) state_d = S_MAP;
      end
      S_MAP: begin
        if (!idx_q[PIX_W]) begin
          hsum      = {1'b0, cdf_q} + {1'b0, hist_mem[idx_q[PIX_W-1:0]]};
          cdf_d     = hsum[CNT_W] ? CNT_MAX : hsum[CNT_W-1:0];
          hw_en     = 1'b1;
          hw_addr   = idx_q[PIX_W-1:0];
          hw_data   = '0;
          m_valid_d = 1'b1;
          m_idx_d   = idx_q[PIX_W-1:0];
          m_cdf_d   = hsum[CNT_W] ? CNT_MAX : hsum[CNT_W-1:0];
          idx_d     = idx_q + 1'b1;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        lut_valid_d = 1'b1;
        n_d         = '0;
        min_pix_d   = PMAX;
        state_d     = S_STREAM;
      end
      default: state_d = S_STREAM;
    endcase

    rd_d = rd_q;
    if (accept) rd_d = (hw_en && hw_addr == in_pixel) ? hw_data : hist_mem[in_pixel];
    v1_d = accept;
    a1_d = accept ? in_pixel : a1_q;

    diff    = m_cdf_q - cdf_min_q;
    prod    = PW'(diff) * PW'(dq_q[SC_W-1:0]);
    shifted = prod >> FRAC_W;
    if (m_cdf_q <= cdf_min_q)      map_val = '0;
    else if (shifted > PW'(PMAX))  map_val = PMAX;
    else                           map_val = shifted[PIX_W-1:0];
    if (m_valid_q) begin
      lw_en   = 1'b1;
      lw_data = ident_q ? m_idx_q : map_val;
    end

    busy_d = (state_d != S_STREAM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_STREAM;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      lut_valid_q <= 1'b0;
      n_q         <= '0;
      min_pix_q   <= PMAX;
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_last_q  <= 1'b0;
      v1_q        <= 1'b0;
      a1_q        <= '0;
      rd_q        <= '0;
      cdf_min_q   <= '0;
      d_q         <= '0;
      ident_q     <= 1'b0;
      rem_q       <= '0;
      dq_q        <= '0;
      div_cnt_q   <= '0;
      idx_q       <= '0;
      cdf_q       <= '0;
      m_valid_q   <= 1'b0;
      m_idx_q     <= '0;
      m_cdf_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      lut_valid_q <= lut_valid_d;
      n_q         <= n_d;
      min_pix_q   <= min_pix_d;
      s1_valid_q  <= s1_valid_d;
      s1_pix_q    <= s1_pix_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_last_q  <= out_last_d;
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      rd_q        <= rd_d;
      cdf_min_q   <= cdf_min_d;
      d_q         <= d_d;
      ident_q     <= ident_d;
      rem_q       <= rem_d;
      dq_q        <= dq_d;
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      cdf_q       <= cdf_d;
      m_valid_q   <= m_valid_d;
      m_idx_q     <= m_idx_d;
      m_cdf_q     <= m_cdf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hw_en) hist_mem[hw_addr] <= hw_data;
    if (lw_en) lut_mem[lw_addr] <= lw_data;
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pix_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign lut_valid = lut_valid_q;

endmodule

// File: tb/tb_hist_equalizer_stream.sv
// tb/tb_hist_equalizer_stream.sv - scoreboard bench for hist_equalizer_stream (PIX_W=4)
module tb_hist_equalizer_stream;
  localparam int PIX_W  = 4;
  localparam int CNT_W  = 22;
  localparam int FRAC_W = 16;
  localparam int NBINS  = 16;
  localparam int PMAX   = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PIX_W-1:0] out_pixel;
  logic             out_last;
  logic             busy;
  logic             lut_valid;

  hist_equalizer_stream #(.PIX_W(PIX_W), .CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last),
    .busy(busy), .lut_valid(lut_valid)
  );

  always #5 clk = ~clk;

  typedef struct {int pix; bit last; int acc;} exp_t;
  exp_t sb[$];
  int   ovr[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  busy_viol = 0;
  bit  chk_lat = 1'b0;
  bit  rnd_ready = 1'b0;

  int  m_hist[NBINS];
  int  m_n;
  int  m_min;
  int  m_lut[NBINS];
  bit  m_lut_valid;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NBINS; i++) m_hist[i] = 0;
    m_n = 0;
    m_min = PMAX;
  endfunction

  function automatic void model_build();
    longint cmin, d, sc, cdf, v;
    cmin = m_hist[m_min];
    d    = m_n - cmin;
    sc   = (d == 0) ? 0 : ((longint'(PMAX) << FRAC_W) / d);
    cdf  = 0;
    for (int i = 0; i < NBINS; i++) begin
      cdf += m_hist[i];
      if (d == 0) m_lut[i] = i;
      else if (cdf <= cmin) m_lut[i] = 0;
      else begin
        v = ((cdf - cmin) * sc) >> FRAC_W;
        m_lut[i] = (v > PMAX) ? PMAX : int'(v);
      end
    end
    model_clear();
    m_lut_valid = 1'b1;
  endfunction

  task automatic step(input bit v, input int p, input bit l, input bit en, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_pixel  = PIX_W'(p);
    in_last   = l;
    enable    = en;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (busy && in_ready) busy_viol++;
    if (out_valid && out_ready) begin
      check_val("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("out_pixel", out_pixel, e.pix);
        check_val("out_last", out_last, e.last);
        if (chk_lat) check_val("latency", cyc - e.acc, 2);
      end
    end
    acc = v && in_ready;
    if (acc) begin
      e.pix  = (ovr.size() > 0) ? ovr.pop_front() : ((en && m_lut_valid) ? m_lut[p] : p);
      e.last = l;
      e.acc  = cyc;
      sb.push_back(e);
      m_n++;
      m_hist[p]++;
      if (p < m_min) m_min = p;
      if (l) model_build();
    end
    cyc++;
  endtask

  task automatic send_frame(input int pix[$], input bit en);
    bit acc;
    int to;
    for (int i = 0; i < pix.size(); i++) begin
      acc = 1'b0;
      to  = 0;
      while (!acc && to < 300) begin
        step(1'b1, pix[i], i == pix.size() - 1, en, acc);
        to++;
      end
      if (!acc) begin
        check_val("accept_timeout", acc, 1);
        return;
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int to = 0;
    bit done = 1'b0;
    while (!done && to < 800) begin
      step(1'b0, 0, 1'b0, 1'b1, acc);
      done = !busy && !out_valid && sb.size() == 0;
      to++;
    end
    check_val("drain_done", done, 1);
    check_val("lut_valid", lut_valid, m_lut_valid);
    check_val("in_ready_while_busy", busy_viol, 0);
    busy_viol = 0;
  endtask

  task automatic do_reset();
    int c = 0;
    int to = 0;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_pixel", out_pixel, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_lut_valid", lut_valid, 0);
    sb.delete();
    ovr.delete();
    model_clear();
    m_lut_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    while (!busy && to < 5) begin
      @(negedge clk);
      #1;
      to++;
    end
    while (busy && c < 100) begin
      c++;
      @(negedge clk);
      #1;
    end
    check_val("init_busy_cycles", c, NBINS);
  endtask

  int  f[$];
  bit  acc_d;

  initial begin
    model_clear();
    m_lut_valid = 1'b0;
    for (int i = 0; i < NBINS; i++) m_lut[i] = i;

    do_reset();
    check_val("lut_valid_after_init", lut_valid, 0);
    chk_lat = 1'b1;
    f = '{7, 12, 0, 15};
    send_frame(f, 1'b1);
    drain();
    chk_lat = 1'b0;

    f.delete();
    for (int i = 0; i < 8; i++) f.push_back(2);
    for (int i = 0; i < 8; i++) f.push_back(5);
    send_frame(f, 1'b1);
    drain();
    ovr = '{0, 15, 0, 15, 0};
    f = '{2, 5, 3, 9, 0};
    send_frame(f, 1'b1);
    drain();

    f.delete();
    for (int i = 0; i < 16; i++) f.push_back(9);
    send_frame(f, 1'b1);
    drain();
    ovr = '{9, 4};
    f = '{9, 4};
    send_frame(f, 1'b1);
    drain();

    rnd_ready = 1'b1;
    f.delete();
    for (int i = 0; i < 64; i++) f.push_back(int'($urandom_range(0, PMAX)));
    send_frame(f, 1'b1);
    drain();

    f.delete();
    for (int i = 0; i < 24; i++) f.push_back(int'($urandom_range(3, 11)));
    send_frame(f, 1'b0);
    drain();
    f.delete();
    for (int i = 0; i < 24; i++) f.push_back(int'($urandom_range(0, PMAX)));
    send_frame(f, 1'b1);
    drain();
    rnd_ready = 1'b0;

    f.delete();
    for (int i = 0; i < 20; i++) f.push_back(int'($urandom_range(0, PMAX)));
    send_frame(f, 1'b1);
    repeat (20) step(1'b0, 0, 1'b0, 1'b1, acc_d);
    check_val("busy_mid_build", busy, 1);
    do_reset();
    f.delete();
    for (int i = 0; i < 12; i++) f.push_back(int'($urandom_range(4, 13)));
    send_frame(f, 1'b1);
    drain();
    f.delete();
    for (int i = 0; i < 16; i++) f.push_back(i);
    send_frame(f, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
